i2c_slave_ctrl: RTL and testbench

- I2C target (slave) engine: the bus counterpart to the team's byte-command I2C master.
- Oversamples SCL/SDA in the WISHBONE clock domain and detects START, repeated START and STOP.
- Matches a 7-bit address, receives write bytes onto a pulse interface, and serves read bytes from a load interface.
- Open-drain SDA drive only; no clock stretching.

---
 rtl/i2c_slave_ctrl.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_i2c_slave_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_ctrl.sv
// I2C target engine: oversamples SCL/SDA in the system clock domain,
// detects START/STOP, matches a 7-bit address, delivers write bytes on a
// pulse interface and serves read bytes from a load interface.
// SDA is open-drain only (sda_pad_o tied low, drive via sda_padoen_o).
module i2c_slave_ctrl #(
    parameter logic [6:0] OWN_ADDR   = 7'h50,
    parameter int         FILTER_LEN = 3
) (
    input  logic       wb_clk_i,
    input  logic       arst_i,
    input  logic       scl_pad_i,
    input  logic       sda_pad_i,
    output logic       sda_pad_o,
    output logic       sda_padoen_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic       rx_nack_i,
    output logic       tx_req_o,
    input  logic [7:0] tx_data_i,
    output logic       start_o,
    output logic       stop_o,
    output logic       busy_o,
    output logic       addr_hit_o
);

    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_LEN - 1);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WRITE, WR_ACK, READ, RD_ACK, WAIT_STOP
    } state_t;

    // Index 0 = SCL, index 1 = SDA
    logic [1:0] w_raw;
    logic [1:0] w_filt;
    logic [1:0] r_filt_d;

    assign w_raw = {sda_pad_i, scl_pad_i};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_in
            logic          r_s1;
            logic          r_s2;
            logic          r_f;
            logic [CW-1:0] r_cnt;

            // Two-stage synchronizer followed by an N-sample agreement filter
            always_ff @(posedge wb_clk_i or negedge arst_i) begin
                if (!arst_i) begin
                    r_s1  <= 1'b1;
                    r_s2  <= 1'b1;
                    r_f   <= 1'b1;
                    r_cnt <= '0;
                end else begin
                    r_s1 <= w_raw[gi];
                    r_s2 <= r_s1;
                    if (r_s2 == r_f) begin
                        r_cnt <= '0;
                    end else if (r_cnt == CNT_MAX) begin
                        r_f   <= r_s2;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end

            assign w_filt[gi] = r_f;
        end
    endgenerate

    // Previous filtered levels for edge detection
    always_ff @(posedge wb_clk_i or negedge arst_i) begin
        if (!arst_i) r_filt_d <= 2'b11;
        else         r_filt_d <= w_filt;
    end

    logic w_scl, w_sda;
    logic w_scl_rise, w_scl_fall, w_start, w_stop;

    assign w_scl      = w_filt[0];
    assign w_sda      = w_filt[1];
    assign w_scl_rise = w_scl & ~r_filt_d[0];
    assign w_scl_fall = ~w_scl & r_filt_d[0];
    assign w_start    = r_filt_d[1] & ~w_sda & w_scl & r_filt_d[0];
    assign w_stop     = ~r_filt_d[1] & w_sda & w_scl & r_filt_d[0];

    state_t     r_state, w_state_next;
    logic [2:0] r_bit_cnt, w_bit_cnt_next;
    logic       r_ack_slot, w_ack_slot_next;
    logic [7:0] r_shift, w_shift_next;
    logic [7:0] r_tx_shift, w_tx_shift_next;
    logic       r_rw, w_rw_next;
    logic       r_mack, w_mack_next;
    logic       r_oen, w_oen_next;
    logic [7:0] r_rx_data, w_rx_data_next;
    logic       r_rx_valid, w_rx_valid_next;
    logic       r_tx_req, w_tx_req_next;
    logic       r_start, w_start_next;
    logic       r_stop, w_stop_next;
    logic       r_busy, w_busy_next;
    logic       r_addr_hit, w_addr_hit_next;
    logic [7:0] w_byte;

    // Byte as it stands once the current SDA sample is shifted in
    assign w_byte = {r_shift[6:0], w_sda};

    // State and datapath registers; reset releases SDA immediately
    always_ff @(posedge wb_clk_i or negedge arst_i) begin
        if (!arst_i) begin
            r_state    <= IDLE;
            r_bit_cnt  <= 3'd0;
            r_ack_slot <= 1'b0;
            r_shift    <= 8'h00;
            r_tx_shift <= 8'h00;
            r_rw       <= 1'b0;
            r_mack     <= 1'b0;
            r_oen      <= 1'b1;
            r_rx_data  <= 8'h00;
            r_rx_valid <= 1'b0;
            r_tx_req   <= 1'b0;
            r_start    <= 1'b0;
            r_stop     <= 1'b0;
            r_busy     <= 1'b0;
            r_addr_hit <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_bit_cnt  <= w_bit_cnt_next;
            r_ack_slot <= w_ack_slot_next;
            r_shift    <= w_shift_next;
            r_tx_shift <= w_tx_shift_next;
            r_rw       <= w_rw_next;
            r_mack     <= w_mack_next;
            r_oen      <= w_oen_next;
            r_rx_data  <= w_rx_data_next;
            r_rx_valid <= w_rx_valid_next;
            r_tx_req   <= w_tx_req_next;
            r_start    <= w_start_next;
            r_stop     <= w_stop_next;
            r_busy     <= w_busy_next;
            r_addr_hit <= w_addr_hit_next;
        end
    end

    // Next-state logic: START/STOP override everything, then per-state bit handling
    always_comb begin
        w_state_next    = r_state;
        w_bit_cnt_next  = r_bit_cnt;
        w_ack_slot_next = r_ack_slot;
        w_shift_next    = r_shift;
        w_tx_shift_next = r_tx_shift;
        w_rw_next       = r_rw;
        w_mack_next     = r_mack;
        w_oen_next      = r_oen;
        w_rx_data_next  = r_rx_data;
        w_rx_valid_next = 1'b0;
        w_tx_req_next   = 1'b0;
        w_start_next    = 1'b0;
        w_stop_next     = 1'b0;
        w_busy_next     = r_busy;
        w_addr_hit_next = r_addr_hit;

        if (w_start) begin
            w_state_next    = ADDR;
            w_bit_cnt_next  = 3'd0;
            w_ack_slot_next = 1'b0;
            w_mack_next     = 1'b0;
            w_oen_next      = 1'b1;
            w_addr_hit_next = 1'b0;
            w_busy_next     = 1'b1;
            w_start_next    = 1'b1;
        end else if (w_stop) begin
            w_state_next    = IDLE;
            w_bit_cnt_next  = 3'd0;
            w_ack_slot_next = 1'b0;
            w_mack_next     = 1'b0;
            w_oen_next      = 1'b1;
            w_addr_hit_next = 1'b0;
            w_busy_next     = 1'b0;
            w_stop_next     = 1'b1;
        end else begin
            case (r_state)
                ADDR: begin
                    if (w_scl_rise && !r_ack_slot) begin
                        w_shift_next = w_byte;
                        if (r_bit_cnt == 3'd7) begin
                            w_bit_cnt_next = 3'd0;
                            if (w_byte[7:1] == OWN_ADDR) begin
                                w_addr_hit_next = 1'b1;
                                w_rw_next       = w_byte[0];
                                w_ack_slot_next = 1'b1;
                            end else begin
                                w_state_next = WAIT_STOP;
                            end
                        end else begin
                            w_bit_cnt_next = r_bit_cnt + 3'd1;
                        end
                    end else if (w_scl_fall && r_ack_slot) begin
                        w_oen_next   = 1'b0;
                        w_state_next = ADDR_ACK;
                    end
                end
                ADDR_ACK: begin
                    if (w_scl_rise && r_rw) begin
                        w_tx_req_next = 1'b1;
                    end else if (w_scl_fall) begin
                        w_ack_slot_next = 1'b0;
                        w_bit_cnt_next  = 3'd0;
                        if (r_rw) begin
                            w_tx_shift_next = tx_data_i;
                            w_oen_next      = tx_data_i[7];
                            w_state_next    = READ;
                        end else begin
                            w_oen_next   = 1'b1;
                            w_state_next = WRITE;
                        end
                    end
                end
                WRITE: begin
                    if (w_scl_rise && !r_ack_slot) begin
                        w_shift_next = w_byte;
                        if (r_bit_cnt == 3'd7) begin
                            w_bit_cnt_next  = 3'd0;
                            w_rx_data_next  = w_byte;
                            w_rx_valid_next = 1'b1;
                            if (!rx_nack_i) w_ack_slot_next = 1'b1;
                            else            w_state_next    = WAIT_STOP;
                        end else begin
                            w_bit_cnt_next = r_bit_cnt + 3'd1;
                        end
                    end else if (w_scl_fall && r_ack_slot) begin
                        w_oen_next   = 1'b0;
                        w_state_next = WR_ACK;
                    end
                end
                WR_ACK: begin
                    if (w_scl_fall) begin
                        w_oen_next      = 1'b1;
                        w_ack_slot_next = 1'b0;
                        w_state_next    = WRITE;
                    end
                end
                READ: begin
                    if (w_scl_rise) begin
                        if (r_bit_cnt == 3'd7) begin
                            w_bit_cnt_next  = 3'd0;
                            w_ack_slot_next = 1'b1;
                            w_mack_next     = 1'b0;
                        end else begin
                            w_bit_cnt_next = r_bit_cnt + 3'd1;
                        end
                    end else if (w_scl_fall) begin
                        if (r_ack_slot) begin
                            w_oen_next   = 1'b1;
                            w_state_next = RD_ACK;
                        end else begin
                            w_oen_next      = r_tx_shift[6];
                            w_tx_shift_next = {r_tx_shift[6:0], 1'b0};
                        end
                    end
                end
                RD_ACK: begin
                    if (w_scl_rise) begin
                        if (!w_sda) begin
                            w_mack_next   = 1'b1;
                            w_tx_req_next = 1'b1;
                        end else begin
                            w_ack_slot_next = 1'b0;
                            w_state_next    = WAIT_STOP;
                        end
                    end else if (w_scl_fall && r_mack) begin
                        w_tx_shift_next = tx_data_i;
                        w_oen_next      = tx_data_i[7];
                        w_ack_slot_next = 1'b0;
                        w_bit_cnt_next  = 3'd0;
                        w_mack_next     = 1'b0;
                        w_state_next    = READ;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sda_pad_o    = 1'b0;
    assign sda_padoen_o = r_oen;
    assign rx_data_o    = r_rx_data;
    assign rx_valid_o   = r_rx_valid;
    assign tx_req_o     = r_tx_req;
    assign start_o      = r_start;
    assign stop_o       = r_stop;
    assign busy_o       = r_busy;
    assign addr_hit_o   = r_addr_hit;

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// Bench for i2c_slave_ctrl: a bit-banged I2C master on an open-drain bus,
// a scoreboard of expected write/read bytes and pulse counters.
module tb_i2c_slave_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       sda_line;
    logic       sda_o, sda_oen;
    logic [7:0] rx_data;
    logic [7:0] tx_data = 8'h00;
    logic       rx_valid, tx_req, start_p, stop_p, busy, addr_hit;
    logic       rx_nack = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    int cnt_start = 0, cnt_stop = 0, cnt_rx = 0, cnt_txreq = 0, cnt_oen_low = 0;

    logic [7:0] rx_exp_q[$];
    logic [7:0] tx_src_q[$];
    logic [7:0] rd_exp_q[$];

    always #5 clk = ~clk;

    // Wired-AND bus: slave only ever pulls low
    assign sda_line = m_sda & (sda_oen | sda_o);

    i2c_slave_ctrl #(.OWN_ADDR(7'h50), .FILTER_LEN(3)) dut (
        .wb_clk_i     (clk),
        .arst_i       (rst_n),
        .scl_pad_i    (scl),
        .sda_pad_i    (sda_line),
        .sda_pad_o    (sda_o),
        .sda_padoen_o (sda_oen),
        .rx_data_o    (rx_data),
        .rx_valid_o   (rx_valid),
        .rx_nack_i    (rx_nack),
        .tx_req_o     (tx_req),
        .tx_data_i    (tx_data),
        .start_o      (start_p),
        .stop_o       (stop_p),
        .busy_o       (busy),
        .addr_hit_o   (addr_hit)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor: pulse counters, write-byte scoreboard, read-byte supply
    always @(negedge clk) begin
        if (rst_n) begin
            if (start_p) cnt_start++;
            if (stop_p) cnt_stop++;
            if (!sda_oen) cnt_oen_low++;
            if (rx_valid) begin
                cnt_rx++;
                check_val("rx_expected", 32'(rx_exp_q.size() > 0), 32'd1);
                if (rx_exp_q.size() > 0) check_val("rx_data", rx_data, rx_exp_q.pop_front());
            end
            if (tx_req) begin
                cnt_txreq++;
                if (tx_src_q.size() > 0) tx_data = tx_src_q.pop_front();
            end
        end
    end

    task automatic bus_wait(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clr_counts();
        cnt_start = 0; cnt_stop = 0; cnt_rx = 0; cnt_txreq = 0; cnt_oen_low = 0;
    endtask

    // START or repeated START (works from SCL high idle or SCL low)
    task automatic i2c_start();
        m_sda = 1'b1; bus_wait(10);
        scl = 1'b1;   bus_wait(10);
        m_sda = 1'b0; bus_wait(10);
        scl = 1'b0;   bus_wait(10);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; bus_wait(10);
        scl = 1'b1;   bus_wait(10);
        m_sda = 1'b1; bus_wait(20);
    endtask

    task automatic send_bit(input logic b);
        m_sda = b;  bus_wait(10);
        scl = 1'b1; bus_wait(20);
        scl = 1'b0; bus_wait(10);
    endtask

    task automatic recv_bit(output logic b);
        m_sda = 1'b1; bus_wait(10);
        scl = 1'b1;   bus_wait(10);
        b = sda_line; bus_wait(10);
        scl = 1'b0;   bus_wait(10);
    endtask

    task automatic write_byte(input logic [7:0] b, input logic exp_ack, input string tag);
        logic ack;
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        recv_bit(ack);
        $display("wr %s byte=0x%02h ack=%0b", tag, b, ack);
        check_val({tag, "_ack"}, 32'(ack), 32'(exp_ack));
    endtask

    task automatic read_byte(input logic mack, input string tag);
        logic [7:0] got;
        logic       b;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            got[i] = b;
        end
        send_bit(mack);
        $display("rd %s byte=0x%02h mack=%0b", tag, got, mack);
        check_val({tag, "_pending"}, 32'(rd_exp_q.size() > 0), 32'd1);
        if (rd_exp_q.size() > 0) check_val(tag, 32'(got), 32'(rd_exp_q.pop_front()));
    endtask

    initial begin
        // Reset state
        bus_wait(5);
        check_val("rst_oen", 32'(sda_oen), 32'd1);
        check_val("rst_rx_data", 32'(rx_data), 32'h00);
        rst_n = 1'b1;
        bus_wait(5);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_hit", 32'(addr_hit), 32'd0);
        check_val("rst_pulses", 32'({start_p, stop_p, rx_valid, tx_req}), 32'd0);

        // Write two bytes
        clr_counts();
        i2c_start();
        check_val("wr_busy", 32'(busy), 32'd1);
        write_byte(8'hA0, 1'b0, "wr_addr");
        check_val("wr_hit", 32'(addr_hit), 32'd1);
        rx_exp_q.push_back(8'h3C);
        write_byte(8'h3C, 1'b0, "wr_d0");
        rx_exp_q.push_back(8'hF1);
        write_byte(8'hF1, 1'b0, "wr_d1");
        i2c_stop();
        check_val("wr_busy_end", 32'(busy), 32'd0);
        check_val("wr_starts", 32'(cnt_start), 32'd1);
        check_val("wr_stops", 32'(cnt_stop), 32'd1);
        check_val("wr_rx_cnt", 32'(cnt_rx), 32'd2);

        // Address miss
        clr_counts();
        i2c_start();
        write_byte(8'hA2, 1'b1, "miss_addr");
        write_byte(8'h55, 1'b1, "miss_d0");
        check_val("miss_hit", 32'(addr_hit), 32'd0);
        check_val("miss_busy", 32'(busy), 32'd1);
        i2c_stop();
        check_val("miss_oen_low", 32'(cnt_oen_low), 32'd0);
        check_val("miss_rx_cnt", 32'(cnt_rx), 32'd0);
        check_val("miss_txreq", 32'(cnt_txreq), 32'd0);
        check_val("miss_busy_end", 32'(busy), 32'd0);

        // Read two bytes, ACK then NACK
        clr_counts();
        tx_src_q.push_back(8'h96); rd_exp_q.push_back(8'h96);
        tx_src_q.push_back(8'h0F); rd_exp_q.push_back(8'h0F);
        i2c_start();
        write_byte(8'hA1, 1'b0, "rd_addr");
        read_byte(1'b0, "rd_b0");
        read_byte(1'b1, "rd_b1");
        cnt_oen_low = 0;
        bus_wait(20);
        check_val("rd_released", 32'(cnt_oen_low), 32'd0);
        check_val("rd_oen", 32'(sda_oen), 32'd1);
        i2c_stop();
        check_val("rd_txreq", 32'(cnt_txreq), 32'd2);

        // Write with application NACK on the second byte
        clr_counts();
        i2c_start();
        write_byte(8'hA0, 1'b0, "nk_addr");
        rx_exp_q.push_back(8'h11);
        write_byte(8'h11, 1'b0, "nk_d0");
        rx_nack = 1'b1;
        rx_exp_q.push_back(8'h22);
        write_byte(8'h22, 1'b1, "nk_d1");
        rx_nack = 1'b0;
        write_byte(8'h33, 1'b1, "nk_d2");
        i2c_stop();
        check_val("nk_rx_cnt", 32'(cnt_rx), 32'd2);

        // Repeated START: write then read
        clr_counts();
        i2c_start();
        write_byte(8'hA0, 1'b0, "sr_waddr");
        rx_exp_q.push_back(8'h01);
        write_byte(8'h01, 1'b0, "sr_d0");
        check_val("sr_hit_wr", 32'(addr_hit), 32'd1);
        i2c_start();
        check_val("sr_hit_drop", 32'(addr_hit), 32'd0);
        tx_src_q.push_back(8'h5A); rd_exp_q.push_back(8'h5A);
        write_byte(8'hA1, 1'b0, "sr_raddr");
        check_val("sr_hit_rd", 32'(addr_hit), 32'd1);
        read_byte(1'b1, "sr_rd");
        i2c_stop();
        check_val("sr_starts", 32'(cnt_start), 32'd2);

        // Glitch on SDA while SCL high
        clr_counts();
        bus_wait(10);
        m_sda = 1'b0; bus_wait(1);
        m_sda = 1'b1; bus_wait(20);
        check_val("glitch_start", 32'(cnt_start), 32'd0);
        check_val("glitch_busy", 32'(busy), 32'd0);

        // Asynchronous reset while the slave drives the address ACK
        i2c_start();
        for (int i = 7; i >= 0; i--) send_bit(1'(8'hA0 >> i));
        check_val("ar_ack_drive", 32'(sda_oen), 32'd0);
        rst_n = 1'b0;
        #1;
        check_val("ar_oen", 32'(sda_oen), 32'd1);
        check_val("ar_busy", 32'(busy), 32'd0);
        check_val("ar_hit", 32'(addr_hit), 32'd0);
        check_val("ar_rx_data", 32'(rx_data), 32'h00);
        scl = 1'b1; m_sda = 1'b1;
        bus_wait(5);
        rst_n = 1'b1;
        clr_counts();
        bus_wait(20);
        check_val("ar_quiet", 32'(cnt_start + cnt_stop + cnt_oen_low), 32'd0);

        check_val("rx_q_empty", 32'(rx_exp_q.size()), 32'd0);
        check_val("rd_q_empty", 32'(rd_exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
